// File: rtl/mac_tx_framer.sv
// rtl/mac_tx_framer.sv - MAC transmit framer: preamble, SFD, payload, pad, CRC-32 FCS, IFG
module mac_tx_framer #(
  parameter int PREAMBLE_LEN = 7,
  parameter int MIN_DATA     = 60,
  parameter int IFG_LEN      = 12
) (
  input  logic       in_clk,
  input  logic       in_rst_n,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  input  logic       in_last,
  output logic       out_ready,
  output logic       out_txen,
  output logic [7:0] out_txd,
  output logic       out_busy,
  output logic       out_underrun
);

  localparam logic [31:0] CRC_POLY = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;
  localparam logic [7:0]  PRE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE = 8'hD5;
  localparam logic [7:0]  PRE_LAST = 8'(PREAMBLE_LEN);
  localparam logic [7:0]  IFG_END  = 8'(IFG_LEN);
  localparam logic [15:0] MIN_CNT  = 16'(MIN_DATA);

  // The SFD has no state of its own: the PRE->DATA edge loads 0xD5, so the
  // SFD byte is on the wire during the first DATA cycle, already accepting.
  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_DATA,
    S_PAD,
    S_FCS,
    S_IFG
  } state_t;

  state_t      state_q;
  logic        txen_q;
  logic [7:0]  txd_q;
  logic        busy_q;
  logic        underrun_q;
  logic [31:0] crc_q;
  logic [15:0] data_cnt_q;
  logic [7:0]  pre_cnt_q;
  logic [1:0]  fcs_idx_q;
  logic [7:0]  ifg_cnt_q;

  logic [15:0] data_cnt_inc;
  logic [31:0] crc_data;
  logic [31:0] crc_pad;
  logic [31:0] fcs_word;
  logic [7:0]  fcs_byte;

  // Reflected CRC-32, one byte per call, LSB of the byte first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
    end
    return r;
  endfunction

  assign data_cnt_inc = (data_cnt_q == 16'hFFFF) ? data_cnt_q : data_cnt_q + 16'd1;
  assign crc_data     = crc32_byte(crc_q, in_data);
  assign crc_pad      = crc32_byte(crc_q, 8'h00);
  assign fcs_word     = ~crc_q;

  // FCS goes out least-significant byte first.
  always_comb begin
    fcs_byte = fcs_word[7:0];
    case (fcs_idx_q)
      2'd0: fcs_byte = fcs_word[7:0];
      2'd1: fcs_byte = fcs_word[15:8];
      2'd2: fcs_byte = fcs_word[23:16];
      2'd3: fcs_byte = fcs_word[31:24];
      default: fcs_byte = fcs_word[7:0];
    endcase
  end

  assign out_ready    = (state_q == S_DATA);
  assign out_txen     = txen_q;
  assign out_txd      = txd_q;
  assign out_busy     = busy_q;
  assign out_underrun = underrun_q;

  // Framing FSM with registered PHY-side outputs.
  always_ff @(posedge in_clk) begin
    if (!in_rst_n) begin
      state_q    <= S_IDLE;
      txen_q     <= 1'b0;
      txd_q      <= 8'h00;
      busy_q     <= 1'b0;
      underrun_q <= 1'b0;
      crc_q      <= CRC_INIT;
      data_cnt_q <= 16'd0;
      pre_cnt_q  <= 8'd0;
      fcs_idx_q  <= 2'd0;
      ifg_cnt_q  <= 8'd0;
    end else begin
      underrun_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          txen_q <= 1'b0;
          txd_q  <= 8'h00;
          if (in_valid) begin
            busy_q     <= 1'b1;
            txen_q     <= 1'b1;
            crc_q      <= CRC_INIT;
            data_cnt_q <= 16'd0;
            pre_cnt_q  <= 8'd1;
            if (PREAMBLE_LEN == 0) begin
              txd_q   <= SFD_BYTE;
              state_q <= S_DATA;
            end else begin
              txd_q   <= PRE_BYTE;
              state_q <= S_PRE;
            end
          end
        end
        S_PRE: begin
          if (pre_cnt_q >= PRE_LAST) begin
            txd_q   <= SFD_BYTE;
            state_q <= S_DATA;
          end else begin
            txd_q     <= PRE_BYTE;
            pre_cnt_q <= pre_cnt_q + 8'd1;
          end
        end
        S_DATA: begin
          if (in_valid) begin
            txd_q      <= in_data;
            crc_q      <= crc_data;
            data_cnt_q <= data_cnt_inc;
            if (in_last) begin
              fcs_idx_q <= 2'd0;
              state_q   <= (data_cnt_inc < MIN_CNT) ? S_PAD : S_FCS;
            end
          end else begin
            // Source starved mid-frame: abort and count this edge as the first IFG cycle.
            txen_q     <= 1'b0;
            txd_q      <= 8'h00;
            underrun_q <= 1'b1;
            ifg_cnt_q  <= 8'd1;
            state_q    <= S_IFG;
          end
        end
        S_PAD: begin
          txd_q      <= 8'h00;
          crc_q      <= crc_pad;
          data_cnt_q <= data_cnt_inc;
          if (data_cnt_inc >= MIN_CNT) begin
            fcs_idx_q <= 2'd0;
            state_q   <= S_FCS;
          end
        end
        S_FCS: begin
          txd_q <= fcs_byte;
          if (fcs_idx_q == 2'd3) begin
            ifg_cnt_q <= 8'd0;
            state_q   <= S_IFG;
          end else begin
            fcs_idx_q <= fcs_idx_q + 2'd1;
          end
        end
        S_IFG: begin
          txen_q <= 1'b0;
          txd_q  <= 8'h00;
          if (ifg_cnt_q >= IFG_END) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            ifg_cnt_q <= ifg_cnt_q + 8'd1;
          end
        end
        default: begin
          txen_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mac_tx_framer.sv
// tb/tb_mac_tx_framer.sv - scoreboard bench for mac_tx_framer
module tb_mac_tx_framer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       v0, l0, v1, l1;
  logic [7:0] d0, d1;
  logic       rdy0, txen0, busy0, ur0;
  logic       rdy1, txen1, busy1, ur1;
  logic [7:0] txd0, txd1;

  // dut0: padding disabled; dut1: default parameters
  mac_tx_framer #(.PREAMBLE_LEN(7), .MIN_DATA(0), .IFG_LEN(12)) dut0 (
    .in_clk(clk), .in_rst_n(rst_n), .in_valid(v0), .in_data(d0), .in_last(l0),
    .out_ready(rdy0), .out_txen(txen0), .out_txd(txd0), .out_busy(busy0), .out_underrun(ur0)
  );

  mac_tx_framer dut1 (
    .in_clk(clk), .in_rst_n(rst_n), .in_valid(v1), .in_data(d1), .in_last(l1),
    .out_ready(rdy1), .out_txen(txen1), .out_txd(txd1), .out_busy(busy1), .out_underrun(ur1)
  );

  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;

  logic [7:0] exp0_q[$];
  logic [7:0] exp1_q[$];
  logic [7:0] frm[256];

  int start_cyc1 = 0;
  int rise_cyc1 = 0;
  int last_hi1 = 0;
  int gap1 = 0;
  int run_cur1 = 0;
  int run1 = 0;
  int ur_cnt1 = 0;
  logic prev1 = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic fail(input string name);
    total_cnt++;
    $display("FAIL %s", name);
  endtask

  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    logic fb;
    r = c;
    for (int i = 0; i < 8; i++) begin
      fb = r[0] ^ d[i];
      r = {1'b0, r[31:1]} ^ (fb ? 32'hEDB88320 : 32'h0);
    end
    return r;
  endfunction

  always @(posedge clk) cyc++;

  // dut0 scoreboard
  always @(negedge clk) begin
    if (txen0) begin
      if (exp0_q.size() == 0) fail("dut0 unexpected byte on txd");
      else chk("dut0 txd", txd0, exp0_q.pop_front());
    end
  end

  // dut1 scoreboard plus frame-shape bookkeeping
  always @(negedge clk) begin
    if (txen1) begin
      if (exp1_q.size() == 0) fail("dut1 unexpected byte on txd");
      else chk("dut1 txd", txd1, exp1_q.pop_front());
      if (!prev1) begin
        gap1 = cyc - last_hi1 - 1;
        rise_cyc1 = cyc;
        run_cur1 = 0;
      end
      run_cur1++;
      last_hi1 = cyc;
    end else if (prev1) begin
      run1 = run_cur1;
    end
    prev1 = txen1;
    if (ur1) ur_cnt1++;
  end

  task automatic drive(input int which, input logic v, input logic [7:0] d, input logic l);
    if (which == 0) begin v0 = v; d0 = d; l0 = l; end
    else begin v1 = v; d1 = d; l1 = l; end
  endtask

  task automatic push(input int which, input logic [7:0] b);
    if (which == 0) exp0_q.push_back(b);
    else exp1_q.push_back(b);
  endtask

  task automatic build_exp(input int which, input int n, input int min_len, input int drop_at);
    logic [31:0] c;
    int cnt;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < 7; i++) push(which, 8'h55);
    push(which, 8'hD5);
    cnt = (drop_at >= 0) ? drop_at : n;
    for (int i = 0; i < cnt; i++) begin
      push(which, frm[i]);
      c = crc_upd(c, frm[i]);
    end
    if (drop_at < 0) begin
      while (cnt < min_len) begin
        push(which, 8'h00);
        c = crc_upd(c, 8'h00);
        cnt++;
      end
      c = ~c;
      push(which, c[7:0]);
      push(which, c[15:8]);
      push(which, c[23:16]);
      push(which, c[31:24]);
    end
  endtask

  task automatic send_frame(input int which, input int n, input int drop_at, input bit keep);
    int i;
    int budget;
    logic r;
    i = 0;
    budget = 0;
    @(posedge clk); #1;
    if (which == 1) start_cyc1 = cyc;
    drive(which, 1'b1, frm[0], n == 1);
    while (i < n && budget < 400) begin
      @(negedge clk);
      r = (which == 0) ? rdy0 : rdy1;
      @(posedge clk); #1;
      budget++;
      if (r) begin
        i++;
        if (i == drop_at) break;
        if (i < n) drive(which, 1'b1, frm[i], i == n - 1);
      end
    end
    if (budget >= 400) fail("send_frame timeout waiting for ready");
    drive(which, keep, 8'h00, 1'b0);
  endtask

  // Waits for txen to fall, then counts busy cycles with txen low.
  task automatic measure_ifg(input int which, output int n, output logic ur_first);
    int b;
    n = 0;
    b = 0;
    ur_first = 1'b0;
    @(negedge clk);
    while (((which == 0) ? txen0 : txen1) && b < 300) begin
      @(negedge clk);
      b++;
    end
    if (b >= 300) fail("timeout waiting for txen low");
    ur_first = (which == 0) ? ur0 : ur1;
    b = 0;
    while (((which == 0) ? busy0 : busy1) && b < 100) begin
      if ((which == 0) ? txen0 : txen1) fail("txen high during IFG");
      n++;
      @(negedge clk);
      b++;
    end
  endtask

  task automatic wait_idle1();
    int b;
    b = 0;
    @(negedge clk);
    while (busy1 && b < 300) begin
      @(negedge clk);
      b++;
    end
    if (b >= 300) fail("timeout waiting for busy low");
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int n;
    int ur_before;
    logic urf;
    rst_n = 1'b0;
    drive(0, 1'b0, 8'h00, 1'b0);
    drive(1, 1'b0, 8'h00, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset txen", txen1, 0);
    chk("reset txd", txd1, 0);
    chk("reset busy", busy1, 0);
    chk("reset underrun", ur1, 0);
    chk("reset ready", rdy1, 0);
    chk("reset txen dut0", txen0, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Test 1: "123456789" with padding disabled, known FCS
    for (int i = 0; i < 9; i++) frm[i] = 8'h31 + 8'(i);
    for (int i = 0; i < 7; i++) exp0_q.push_back(8'h55);
    exp0_q.push_back(8'hD5);
    for (int i = 0; i < 9; i++) exp0_q.push_back(frm[i]);
    exp0_q.push_back(8'h26);
    exp0_q.push_back(8'h39);
    exp0_q.push_back(8'hF4);
    exp0_q.push_back(8'hCB);
    send_frame(0, 9, -1, 1'b0);
    measure_ifg(0, n, urf);
    chk("t1 ifg cycles", n, 12);
    chk("t1 all bytes sent", exp0_q.size(), 0);

    // Test 2: single byte, padded to 60
    frm[0] = 8'hAB;
    build_exp(1, 1, 60, -1);
    send_frame(1, 1, -1, 1'b0);
    measure_ifg(1, n, urf);
    chk("t2 txen run length", run1, 72);
    chk("t2 start latency", rise_cyc1 - start_cyc1, 1);
    chk("t2 ifg cycles", n, 12);
    chk("t2 all bytes sent", exp1_q.size(), 0);

    // Test 3: exactly minimum payload, no pad
    for (int i = 0; i < 60; i++) frm[i] = 8'(i + 1);
    build_exp(1, 60, 60, -1);
    send_frame(1, 60, -1, 1'b0);
    wait_idle1();
    chk("t3 txen run length", run1, 72);
    chk("t3 all bytes sent", exp1_q.size(), 0);

    // Test 4: underrun after 10 payload bytes
    for (int i = 0; i < 20; i++) frm[i] = 8'hA0 + 8'(i);
    build_exp(1, 20, 60, 10);
    ur_before = ur_cnt1;
    send_frame(1, 20, 10, 1'b0);
    measure_ifg(1, n, urf);
    chk("t4 underrun at abort", urf, 1);
    chk("t4 underrun width", ur_cnt1 - ur_before, 1);
    chk("t4 busy cycles after abort", n, 12);
    chk("t4 txen run length", run1, 18);
    chk("t4 no fcs sent", exp1_q.size(), 0);

    // Test 5: back-to-back frames with valid held high
    for (int i = 0; i < 5; i++) frm[i] = 8'h10 + 8'(i);
    build_exp(1, 5, 60, -1);
    send_frame(1, 5, -1, 1'b1);
    for (int i = 0; i < 61; i++) frm[i] = 8'h80 ^ 8'(i * 3);
    build_exp(1, 61, 60, -1);
    send_frame(1, 61, -1, 1'b0);
    wait_idle1();
    chk("t5 inter-frame gap", gap1, 13);
    chk("t5 second run length", run1, 73);
    chk("t5 all bytes sent", exp1_q.size(), 0);

    // Test 6: reset during pad, then a clean frame
    frm[0] = 8'h11;
    build_exp(1, 1, 60, -1);
    send_frame(1, 1, -1, 1'b0);
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp1_q.delete();
    @(negedge clk);
    chk("t6 txen after reset", txen1, 0);
    chk("t6 busy after reset", busy1, 0);
    repeat (3) @(negedge clk);
    chk("t6 txen stays low", txen1, 0);
    frm[0] = 8'hDE;
    frm[1] = 8'hAD;
    frm[2] = 8'hBE;
    build_exp(1, 3, 60, -1);
    send_frame(1, 3, -1, 1'b0);
    wait_idle1();
    chk("t6 all bytes sent", exp1_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
